// File: rtl/w5300_pkg.sv
// Shared types and elaboration-time helpers for the W5300 host-bus master.
package w5300_pkg;

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } w5300_state_e;

  // 32-bit integer arithmetic; callers clamp a zero result.
  function automatic int unsigned ns_to_ticks(input int unsigned ns, input int unsigned mhz);
    return (ns * mhz) / 32'd1000;
  endfunction

  function automatic bit data_w_legal(input int unsigned w);
    return (w == 32'd8) || (w == 32'd16);
  endfunction

endpackage

// File: rtl/w5300_tick_timer.sv
// Loadable down-counter that parks at zero; shared by the reset phases, STROBE and RECOVER.
module w5300_tick_timer #(
  parameter int unsigned Width    = 8,
  parameter int unsigned ResetVal = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             expired_o
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= Width'(ResetVal);
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign expired_o = (value_q == '0);

endmodule

// File: rtl/w5300_bus_master.sv
// W5300 host-bus master: hard-reset sequencing, then single/burst accesses with
// programmable strobe and recovery timing. All bus outputs are registered.
module w5300_bus_master
  import w5300_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ  = 100,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned T_RST_LOW_NS  = 2000,
  parameter int unsigned T_RST_WAIT_NS = 50000,
  parameter int unsigned STROBE_CYC    = 7,
  parameter int unsigned RECOVERY_CYC  = 3,
  parameter int unsigned BURST_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BURST_W-1:0] req_cnt,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              wr_next,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              hw_rst_n,
  output logic [ADDR_W-1:0] addr,
  output logic              cs_n,
  output logic              rd_n,
  output logic              we_n,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("w5300_bus_master: DATA_W must be 8 or 16");
  end

  localparam int unsigned RstLowRaw    = ns_to_ticks(T_RST_LOW_NS, CLK_FREQ_MHZ);
  localparam int unsigned RstWaitRaw   = ns_to_ticks(T_RST_WAIT_NS, CLK_FREQ_MHZ);
  localparam int unsigned RstLowTicks  = (RstLowRaw == 0) ? 1 : RstLowRaw;
  localparam int unsigned RstWaitTicks = (RstWaitRaw == 0) ? 1 : RstWaitRaw;
  localparam int unsigned RstMax  = (RstLowTicks > RstWaitTicks) ? RstLowTicks : RstWaitTicks;
  localparam int unsigned CycMax  = (STROBE_CYC > RECOVERY_CYC) ? STROBE_CYC : RECOVERY_CYC;
  localparam int unsigned TmrMax  = (RstMax > CycMax) ? RstMax : CycMax;
  localparam int unsigned TmrW    = (TmrMax < 2) ? 1 : $clog2(TmrMax);

  w5300_state_e state_d, state_q;
  logic               we_d, we_q;
  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic [BURST_W-1:0] cnt_d, cnt_q;
  logic [DATA_W-1:0]  data_o_d, data_o_q;
  logic [DATA_W-1:0]  rd_data_d, rd_data_q;
  logic hw_rst_n_d, hw_rst_n_q, cs_n_d, cs_n_q, rd_n_d, rd_n_q, we_n_d, we_n_q;
  logic data_oe_d, data_oe_q, ready_d, ready_q, rd_valid_d, rd_valid_q;
  logic wr_next_d, wr_next_q, done_d, done_q;

  logic            tmr_load;
  logic [TmrW-1:0] tmr_load_val, tmr_value;
  logic            tmr_expired;
  logic            unused_tmr_value;

  assign unused_tmr_value = ^tmr_value;

  // Reset value lets the RST_LOW phase start counting straight out of rst_n.
  w5300_tick_timer #(
    .Width    (TmrW),
    .ResetVal (RstLowTicks - 1)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    data_o_d     = data_o_q;
    rd_data_d    = rd_data_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    done_d       = 1'b0;
    case (state_q)
      StRstLow: begin
        if (tmr_expired) begin
          state_d      = StRstWait;
          tmr_load     = 1'b1;
          tmr_load_val = TmrW'(RstWaitTicks - 1);
        end
      end
      StRstWait: begin
        if (tmr_expired) state_d = StIdle;
      end
      StIdle: begin
        if (sw_reset) begin
          state_d      = StRstLow;
          tmr_load     = 1'b1;
          tmr_load_val = TmrW'(RstLowTicks - 1);
        end else if (req) begin
          state_d = StSetup;
          we_d    = req_we;
          addr_d  = req_addr;
          cnt_d   = (req_cnt == '0) ? BURST_W'(1) : req_cnt;
          if (req_we) data_o_d = req_wdata;
        end
      end
      StSetup: begin
        state_d      = StStrobe;
        tmr_load     = 1'b1;
        tmr_load_val = TmrW'(STROBE_CYC - 1);
      end
      StStrobe: begin
        if (tmr_expired) begin
          state_d = StHold;
          if (!we_q) rd_data_d = data_i;
        end
      end
      StHold: begin
        state_d      = StRecover;
        cnt_d        = cnt_q - BURST_W'(1);
        tmr_load     = 1'b1;
        tmr_load_val = TmrW'(RECOVERY_CYC - 1);
      end
      StRecover: begin
        if (tmr_expired) begin
          if (cnt_q != '0) begin
            state_d = StSetup;
            if (we_q) data_o_d = req_wdata;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StRstLow;
    endcase
  end

  // Outputs decoded from the next state so each flop lines up with state_q.
  always_comb begin
    hw_rst_n_d = (state_d != StRstLow);
    cs_n_d     = !(state_d inside {StSetup, StStrobe, StHold});
    rd_n_d     = !((state_d == StStrobe) && !we_d);
    we_n_d     = !((state_d == StStrobe) && we_d);
    data_oe_d  = we_d && (state_d inside {StSetup, StStrobe, StHold});
    ready_d    = (state_d == StIdle);
    rd_valid_d = (state_d == StHold) && !we_d;
    wr_next_d  = (state_d == StHold) && we_d && (cnt_q > BURST_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRstLow;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_o_q   <= '0;
      rd_data_q  <= '0;
      hw_rst_n_q <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_next_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_o_q   <= data_o_d;
      rd_data_q  <= rd_data_d;
      hw_rst_n_q <= hw_rst_n_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      we_n_q     <= we_n_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      wr_next_q  <= wr_next_d;
      done_q     <= done_d;
    end
  end

  assign hw_rst_n = hw_rst_n_q;
  assign addr     = addr_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign we_n     = we_n_q;
  assign data_o   = data_o_q;
  assign data_oe  = data_oe_q;
  assign rd_data  = rd_data_q;
  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign wr_next  = wr_next_q;
  assign done     = done_q;

endmodule

// File: doc/w5300_bus_master.md
Name: w5300_bus_master

Overview:
Parametrised successor to the W5300 async parallel interface. It sequences the chip hard reset, then runs single or burst read/write cycles on the W5300 host bus using programmable strobe, hold and recovery timing. A req/ready handshake faces the user side. The data bus is split into in, out and output-enable; the tristate buffer lives in the top level. Burst mode repeats accesses at one address, for the Sn_TX_FIFOR/Sn_RX_FIFOR registers.

Parameters:
CLK_FREQ_MHZ, 100, clk frequency in MHz
DATA_W, 16, host data width; legal values 8 or 16
ADDR_W, 10, host address width
T_RST_LOW_NS, 2000, hw_rst_n low time
T_RST_WAIT_NS, 50000, wait after hw_rst_n release before ready
STROBE_CYC, 7, rd_n/we_n low cycles, >=1
RECOVERY_CYC, 3, cs_n high cycles between words, >=1
BURST_W, 8, width of req_cnt

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sw_reset  in  1  re-run the hard-reset sequence; honoured in IDLE only
req  in  1  access request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_cnt  in  BURST_W  word count; 0 is treated as 1
req_wdata  in  DATA_W  write word, sampled on SETUP entry of each word
ready  out  1  idle and able to accept req
wr_next  out  1  pulse: current write word consumed, present the next one
rd_valid  out  1  pulse: rd_data holds a new word
rd_data  out  DATA_W  registered read word
done  out  1  pulse: transfer complete
hw_rst_n  out  1  W5300 RESET pin
addr  out  ADDR_W  host address
cs_n, rd_n, we_n  out  1 each  host strobes
data_o  out  DATA_W  bus drive value
data_oe  out  1  bus drive enable
data_i  in  DATA_W  bus sample value

Behaviour:
- Reset values: hw_rst_n=0, cs_n=rd_n=we_n=1, data_oe=0, addr=0, data_o=0, rd_data=0, ready=0, all pulses 0. The FSM goes to RST_LOW.
- Tick counts: RST_LOW_TICKS = T_RST_LOW_NS*CLK_FREQ_MHZ/1000 (200 at defaults). RST_WAIT_TICKS uses the same formula (5000 at defaults). Both are computed in 32-bit integer arithmetic. The counter width is clog2 of the larger value.
- RST_LOW: hw_rst_n=0 for exactly RST_LOW_TICKS cycles, then go to RST_WAIT.
- RST_WAIT: hw_rst_n=1 for exactly RST_WAIT_TICKS cycles, then go to IDLE with ready=1.
- IDLE: ready=1.
  - sw_reset=1 takes priority over req: go to RST_LOW.
  - req=1: latch we, addr and count (0 is treated as 1), set ready=0, go to SETUP.
  - req while ready=0 is ignored, not queued.
- SETUP (1 cycle): addr driven and cs_n=0.
  - Write: latch req_wdata into data_o and set data_oe=1.
- STROBE (STROBE_CYC cycles): rd_n=0 for a read, we_n=0 for a write.
  - Read: data_i is registered into rd_data on the last STROBE cycle.
- HOLD (1 cycle): strobes high, cs_n=0 and data still driven.
  - Read: rd_valid=1.
  - Write: wr_next=1 only if more words remain.
  - Remaining count decrements by one.
- RECOVER (RECOVERY_CYC cycles): cs_n=1 and data_oe=0. Then go to SETUP if words remain, otherwise to IDLE with done=1 and ready=1 in that same cycle.
- Single-read latency at defaults: req accepted at edge 0; SETUP in cycle 1; STROBE in cycles 2–8; rd_valid in cycle 9; RECOVER in cycles 10–12; done and ready in cycle 13. A write has the same timing.
- Burst: addr is constant for the whole burst; each word repeats SETUP..RECOVER.
- DATA_W=8: all behaviour is identical and the bus is 8 bits wide.
- Asynchronous rst_n mid-transfer: all outputs return to their reset values immediately, and the reset sequence restarts. No done pulse is issued.
- rd_n and we_n are never low in the same cycle. cs_n is never high while a strobe is low.

Decomposition:
- Shared package w5300_pkg holds:
  - the state enum: RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD, RECOVER;
  - the function ns_to_ticks(ns, mhz);
  - DATA_W legality checks.
- Sub-module w5300_tick_timer: a loadable down-counter with load, value and expired outputs. It is reused for the reset phases, STROBE and RECOVER.

Test Plan:
1. Power-up, CLK_FREQ_MHZ=100 → hw_rst_n low for exactly 200 cycles, then high; ready rises exactly 5000 cycles after hw_rst_n rises.
2. Single read: addr 0x208, data_i=0xA55A → rd_n low for exactly 7 cycles; rd_valid in cycle 9 with rd_data=0xA55A; done in cycle 13.
3. Write burst: addr 0x22E, cnt 3, words 0x1111/0x2222/0x3333 supplied on wr_next → 3 we_n pulses with data_o matching; 2 wr_next pulses; addr constant; data_oe=0 in every RECOVER cycle.
4. req_cnt=0 → exactly one access; req held while busy → no second transfer starts.
5. rst_n asserted in cycle 5 of STROBE → cs_n, we_n and rd_n go high and data_oe goes 0 immediately; hw_rst_n=0; no done pulse.
6. sw_reset and req both high in IDLE → reset sequence runs and the request is dropped. Separately, DATA_W=8 with a read of 0x3C → rd_data=0x3C.
